math_sched: RTL and testbench

//  Issue scheduler for the integer math pipe: holds renamed ALU/branch/vector-ALU micro-ops

---
 rtl/math_sched_pkg.sv | 28 ++
 rtl/math_sched_select.sv | 21 ++
 rtl/math_sched.sv | 133 +++++++++++++
 tb/tb_math_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/math_sched_pkg.sv
// Shared types and field helpers for the integer math issue scheduler.
// Micro-op payload layout is {rs2, rs1, rob}, identical to the EX00 operand stage input.
package math_sched_pkg;

    localparam int unsigned TAG_W  = 6;
    localparam int unsigned ROB_W  = 6;
    localparam int unsigned DATA_W = 18;

    typedef struct packed {
        logic              valid;
        logic              rs1_rdy;
        logic              rs2_rdy;
        logic [DATA_W-1:0] data;
    } sched_entry_t;

    function automatic logic [TAG_W-1:0] rs1_of(input logic [DATA_W-1:0] d);
        return d[2*TAG_W-1:TAG_W];
    endfunction

    function automatic logic [TAG_W-1:0] rs2_of(input logic [DATA_W-1:0] d);
        return d[DATA_W-1:2*TAG_W];
    endfunction

    function automatic logic [ROB_W-1:0] rob_of(input logic [DATA_W-1:0] d);
        return d[ROB_W-1:0];
    endfunction

endpackage

// File: rtl/math_sched_select.sv
// Oldest-first picker: slot 0 is the oldest entry, so the lowest set ready bit wins.
module math_sched_select #(
    parameter int unsigned ENTRIES = 8
) (
    input  logic [ENTRIES-1:0] ready_vec,
    output logic [ENTRIES-1:0] pick,
    output logic               any_ready
);

    always_comb begin
        pick      = '0;
        any_ready = 1'b0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (ready_vec[i] && !any_ready) begin
                pick[i]   = 1'b1;
                any_ready = 1'b1;
            end
        end
    end

endmodule

// File: rtl/math_sched.sv
// Issue queue for the integer math pipe: age-ordered by compaction, oldest ready op issues.
// MATH_SCHED_WAKE_BYPASS_EN lets this cycle's wakeups feed select directly.
module math_sched
    import math_sched_pkg::*;
#(
    parameter int unsigned ENTRIES    = 8,
    parameter int unsigned WAKE_PORTS = 3,
    localparam int unsigned CNT_W     = $clog2(ENTRIES + 1)
) (
    input  logic                        cpu_clock_i,
    input  logic                        cpu_reset_i,
    input  logic                        flush_i,
    input  logic                        enq_valid_i,
    input  logic [DATA_W-1:0]           enq_data_i,
    input  logic                        enq_rs1_rdy_i,
    input  logic                        enq_rs2_rdy_i,
    output logic                        enq_ready_o,
    input  logic [WAKE_PORTS-1:0]       wake_valid_i,
    input  logic [TAG_W*WAKE_PORTS-1:0] wake_tag_i,
    output logic                        issue_valid_o,
    output logic [DATA_W-1:0]           issue_data_o,
    output logic [CNT_W-1:0]            occupancy_o,
    output logic                        empty_o
);

    sched_entry_t        ent_q [ENTRIES];
    sched_entry_t        ent_d [ENTRIES];
    sched_entry_t        ent_w [ENTRIES+1];
    sched_entry_t        new_ent;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_base;
    logic                issue_valid_q, issue_valid_d;
    logic [DATA_W-1:0]   issue_data_q, issue_data_d;
    logic [ENTRIES-1:0]  sel_rdy, pick;
    logic                pick_any;
    logic                enq_ok;

    function automatic logic woken(input logic [TAG_W-1:0]            tag,
                                   input logic [WAKE_PORTS-1:0]       wv,
                                   input logic [TAG_W*WAKE_PORTS-1:0] wt);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < int'(WAKE_PORTS); p++) begin
            hit |= wv[p] && (wt[p*TAG_W +: TAG_W] == tag);
        end
        return hit;
    endfunction

    // Entries with this cycle's wakeups applied; the extra top slot feeds compaction.
    always_comb begin
        for (int i = 0; i < int'(ENTRIES); i++) begin
            ent_w[i] = ent_q[i];
            if (ent_q[i].valid) begin
                if (woken(rs1_of(ent_q[i].data), wake_valid_i, wake_tag_i)) ent_w[i].rs1_rdy = 1'b1;
                if (woken(rs2_of(ent_q[i].data), wake_valid_i, wake_tag_i)) ent_w[i].rs2_rdy = 1'b1;
            end
        end
        ent_w[ENTRIES] = '0;
    end

    always_comb begin
        for (int i = 0; i < int'(ENTRIES); i++) begin
`ifdef MATH_SCHED_WAKE_BYPASS_EN
            sel_rdy[i] = ent_w[i].valid & ent_w[i].rs1_rdy & ent_w[i].rs2_rdy;
`else
            sel_rdy[i] = ent_q[i].valid & ent_q[i].rs1_rdy & ent_q[i].rs2_rdy;
`endif
        end
    end

    math_sched_select #(
        .ENTRIES (ENTRIES)
    ) u_select (
        .ready_vec (sel_rdy),
        .pick      (pick),
        .any_ready (pick_any)
    );

    assign enq_ready_o = cnt_q < CNT_W'(ENTRIES);
    assign enq_ok      = enq_valid_i & enq_ready_o;
    assign cnt_base    = cnt_q - CNT_W'(pick_any);

    // x0 and same-cycle wakeups are captured as ready so no wakeup is lost.
    always_comb begin
        new_ent.valid   = 1'b1;
        new_ent.data    = enq_data_i;
        new_ent.rs1_rdy = enq_rs1_rdy_i || (rs1_of(enq_data_i) == '0)
                          || woken(rs1_of(enq_data_i), wake_valid_i, wake_tag_i);
        new_ent.rs2_rdy = enq_rs2_rdy_i || (rs2_of(enq_data_i) == '0)
                          || woken(rs2_of(enq_data_i), wake_valid_i, wake_tag_i);
    end

    always_comb begin
        logic              seen;
        logic [DATA_W-1:0] pick_data;
        seen      = 1'b0;
        pick_data = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            pick_data |= pick[i] ? ent_q[i].data : '0;
            seen      |= pick[i];
            ent_d[i]   = seen ? ent_w[i+1] : ent_w[i];
            if (enq_ok && (cnt_base == CNT_W'(i))) ent_d[i] = new_ent;
        end
        cnt_d         = cnt_base + CNT_W'(enq_ok);
        issue_valid_d = pick_any;
        issue_data_d  = pick_any ? pick_data : issue_data_q;
        if (flush_i) begin
            for (int i = 0; i < int'(ENTRIES); i++) ent_d[i] = '0;
            cnt_d         = '0;
            issue_valid_d = 1'b0;
            issue_data_d  = issue_data_q;
        end
    end

    always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
        if (cpu_reset_i) begin
            for (int i = 0; i < int'(ENTRIES); i++) ent_q[i] <= '0;
            cnt_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_data_q  <= '0;
        end else begin
            for (int i = 0; i < int'(ENTRIES); i++) ent_q[i] <= ent_d[i];
            cnt_q         <= cnt_d;
            issue_valid_q <= issue_valid_d;
            issue_data_q  <= issue_data_d;
        end
    end

    assign issue_valid_o = issue_valid_q;
    assign issue_data_o  = issue_data_q;
    assign occupancy_o   = cnt_q;
    assign empty_o       = (cnt_q == '0);

endmodule

// File: tb/tb_math_sched.sv
// Scoreboard bench for math_sched: an age-ordered op list models the queue each edge and
// queues the expected outputs; a negedge monitor pops and compares them.
module tb_math_sched;

    localparam int ENTRIES = 8;
    localparam int WP      = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          enq_valid = 1'b0;
    logic [17:0]   enq_data = '0;
    logic          enq_r1 = 1'b0;
    logic          enq_r2 = 1'b0;
    logic [WP-1:0] wake_valid = '0;
    logic [6*WP-1:0] wake_tag = '0;
    logic          enq_ready, issue_valid, empty;
    logic [17:0]   issue_data;
    logic [3:0]    occ;

    math_sched u_dut (
        .cpu_clock_i   (clk),
        .cpu_reset_i   (rst),
        .flush_i       (flush),
        .enq_valid_i   (enq_valid),
        .enq_data_i    (enq_data),
        .enq_rs1_rdy_i (enq_r1),
        .enq_rs2_rdy_i (enq_r2),
        .enq_ready_o   (enq_ready),
        .wake_valid_i  (wake_valid),
        .wake_tag_i    (wake_tag),
        .issue_valid_o (issue_valid),
        .issue_data_o  (issue_data),
        .occupancy_o   (occ),
        .empty_o       (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] data;
        bit          r1;
        bit          r2;
    } op_t;

    typedef struct {
        bit          v;
        logic [17:0] d;
        int          occ;
    } exp_t;

    op_t         mq[$];
    exp_t        exp_q[$];
    logic [17:0] last_data = '0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit woken(input logic [5:0] t);
        for (int p = 0; p < WP; p++)
            if (wake_valid[p] && wake_tag[p*6 +: 6] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit can_issue(input op_t o);
`ifdef MATH_SCHED_WAKE_BYPASS_EN
        return (o.r1 || woken(o.data[11:6])) && (o.r2 || woken(o.data[17:12]));
`else
        return o.r1 && o.r2;
`endif
    endfunction

    // Reference model: list in age order, one pick per edge, stale-ready entries may wait.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            last_data = '0;
            exp_q.push_back('{v: 1'b0, d: 18'd0, occ: 0});
        end else if (flush) begin
            mq.delete();
            exp_q.push_back('{v: 1'b0, d: last_data, occ: 0});
        end else begin
            int n0;
            int k;
            bit v;
            n0 = mq.size();
            k  = -1;
            v  = 1'b0;
            for (int i = 0; i < mq.size(); i++) begin
                if (can_issue(mq[i])) begin
                    k = i;
                    break;
                end
            end
            if (k >= 0) begin
                v         = 1'b1;
                last_data = mq[k].data;
                mq.delete(k);
            end
            foreach (mq[i]) begin
                if (woken(mq[i].data[11:6]))  mq[i].r1 = 1'b1;
                if (woken(mq[i].data[17:12])) mq[i].r2 = 1'b1;
            end
            if (enq_valid && n0 < ENTRIES) begin
                op_t o;
                o.data = enq_data;
                o.r1   = enq_r1 || enq_data[11:6] == 6'd0 || woken(enq_data[11:6]);
                o.r2   = enq_r2 || enq_data[17:12] == 6'd0 || woken(enq_data[17:12]);
                mq.push_back(o);
            end
            exp_q.push_back('{v: v, d: last_data, occ: mq.size()});
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("issue_valid", 32'(issue_valid), 32'(e.v));
            check("issue_data", 32'(issue_data), 32'(e.d));
            check("occupancy", 32'(occ), 32'(e.occ));
            check("empty", 32'(empty), 32'(e.occ == 0));
            check("enq_ready", 32'(enq_ready), 32'(e.occ < ENTRIES));
        end
    end

    task automatic enq(input logic [5:0] rob, input logic [5:0] rs1, input logic [5:0] rs2,
                       input bit r1, input bit r2);
        enq_valid = 1'b1;
        enq_data  = {rs2, rs1, rob};
        enq_r1    = r1;
        enq_r2    = r2;
    endtask

    task automatic wake(input int p, input logic [5:0] t);
        wake_valid[p]      = 1'b1;
        wake_tag[p*6 +: 6] = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        enq_valid  = 1'b0;
        enq_r1     = 1'b0;
        enq_r2     = 1'b0;
        wake_valid = '0;
        flush      = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Ready op issues the cycle after enqueue.
        enq(6'd3, 6'd0, 6'd0, 1'b1, 1'b1);
        tick();
        repeat (2) tick();

        // Younger ready op overtakes an older waiter.
        enq(6'd1, 6'd5, 6'd0, 1'b0, 1'b1);
        tick();
        enq(6'd2, 6'd7, 6'd0, 1'b1, 1'b1);
        tick();
        wake(0, 6'd5);
        tick();
        repeat (3) tick();

        // Fill, overflow attempt, then wake in age order.
        for (int i = 0; i < ENTRIES; i++) begin
            enq(6'(i), 6'(10 + i), 6'd0, 1'b0, 1'b1);
            tick();
        end
        enq(6'd9, 6'd20, 6'd0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < ENTRIES; i += 3) begin
            for (int p = 0; p < WP; p++)
                if (i + p < ENTRIES) wake(p, 6'(10 + i + p));
            tick();
        end
        repeat (10) tick();

        // Wakeup in the enqueue cycle is not lost.
        enq(6'd4, 6'd0, 6'd9, 1'b1, 1'b0);
        wake(2, 6'd9);
        tick();
        repeat (3) tick();

        // Flush beats a same-cycle enqueue.
        for (int i = 0; i < 4; i++) begin
            enq(6'(i), 6'(30 + i), 6'd0, 1'b0, 1'b1);
            tick();
        end
        flush = 1'b1;
        enq(6'd7, 6'd0, 6'd0, 1'b1, 1'b1);
        tick();
        repeat (2) tick();

        // Asynchronous reset while ops are issuing.
        for (int i = 0; i < 4; i++) begin
            enq(6'(40 + i), 6'd0, 6'd0, 1'b1, 1'b1);
            tick();
        end
        #1 rst = 1'b1;
        #1;
        check("rst_issue_valid", 32'(issue_valid), 32'd0);
        check("rst_issue_data", 32'(issue_data), 32'd0);
        check("rst_occupancy", 32'(occ), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_enq_ready", 32'(enq_ready), 32'd1);
        mq.delete();
        exp_q.delete();
        last_data = '0;
        tick();
        rst = 1'b0;
        tick();

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 1) == 0)
                enq(6'($urandom_range(0, 63)), 6'($urandom_range(0, 15)),
                    6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
            for (int p = 0; p < WP; p++)
                if ($urandom_range(0, 1) == 0) wake(p, 6'($urandom_range(0, 15)));
            if ($urandom_range(0, 63) == 0) flush = 1'b1;
            tick();
        end
        flush = 1'b1;
        tick();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
